// File: rtl/regfile_uart_dump_if.sv
// Bus between the register-file dump engine and its surroundings: dump control,
// RAM read port and the serial TX line.
interface regfile_uart_dump_if;
  logic       start;
  logic [7:0] first_addr;
  logic [7:0] last_addr;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       txd;
  logic       busy;
  logic       done;

  // The dump engine.
  modport slave (
    input  start, first_addr, last_addr, mem_data,
    output mem_addr, txd, busy, done
  );

  // Whatever requests dumps and serves the RAM read port.
  modport master (
    output start, first_addr, last_addr, mem_data,
    input  mem_addr, txd, busy, done
  );
endinterface

// File: rtl/regfile_uart_dump.sv
// Streams RAM[first..last] (8-bit wrapping) over UART 8N1 as "AA:DD\r\n" lines,
// uppercase hex, characters back-to-back within a line.
module regfile_uart_dump #(
  parameter int unsigned ClksPerBit = 434
) (
  input logic               clk,
  input logic               reset,
  regfile_uart_dump_if.slave bus
);

  localparam logic [15:0] BitEnd = 16'(ClksPerBit - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StLatch, StSend} state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  last_q, last_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [2:0]  char_idx_q, char_idx_d;
  logic        done_q, done_d;

  logic        bit_end, char_end, line_end;
  logic [7:0]  cur_char;
  logic [9:0]  frame;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign bit_end  = (clk_cnt_q == BitEnd);
  assign char_end = bit_end && (bit_idx_q == 4'd9);
  assign line_end = char_end && (char_idx_q == 3'd6);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      addr_q     <= 8'h00;
      last_q     <= 8'h00;
      data_q     <= 8'h00;
      clk_cnt_q  <= 16'h0;
      bit_idx_q  <= 4'h0;
      char_idx_q <= 3'h0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      data_q     <= data_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      char_idx_q <= char_idx_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StFetch;
      StFetch: state_d = StLatch;
      StLatch: state_d = StSend;
      StSend:  if (line_end) state_d = (addr_q == last_q) ? StIdle : StFetch;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    last_d     = last_q;
    data_d     = data_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    char_idx_d = char_idx_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d = bus.first_addr;
          last_d = bus.last_addr;
        end
      end
      StLatch: begin
        data_d     = bus.mem_data;
        clk_cnt_d  = 16'h0;
        bit_idx_d  = 4'h0;
        char_idx_d = 3'h0;
      end
      StSend: begin
        clk_cnt_d = bit_end ? 16'h0 : clk_cnt_q + 16'h1;
        if (bit_end) bit_idx_d = char_end ? 4'h0 : bit_idx_q + 4'h1;
        if (char_end) char_idx_d = line_end ? 3'h0 : char_idx_q + 3'h1;
        if (line_end) begin
          if (addr_q == last_q) done_d = 1'b1;
          else                  addr_d = addr_q + 8'h01;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cur_char = 8'h0A;
    unique case (char_idx_q)
      3'd0:    cur_char = hex_char(addr_q[7:4]);
      3'd1:    cur_char = hex_char(addr_q[3:0]);
      3'd2:    cur_char = 8'h3A;
      3'd3:    cur_char = hex_char(data_q[7:4]);
      3'd4:    cur_char = hex_char(data_q[3:0]);
      3'd5:    cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
    // Stop bit, data LSB first, start bit.
    frame        = {1'b1, cur_char, 1'b0};
    bus.txd      = (state_q == StSend) ? frame[bit_idx_q] : 1'b1;
    bus.busy     = (state_q != StIdle);
    bus.done     = done_q;
    bus.mem_addr = addr_q;
  end

endmodule

// File: tb/tb_regfile_uart_dump.sv
// Directed bench for regfile_uart_dump: decodes TX frames cycle-exactly against
// hand-written expected text.
module tb_regfile_uart_dump;

  localparam int unsigned C = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [7:0] ram [256];
  logic       cnt_clr = 1'b0;
  int         busy_cycles = 0;
  int         done_count = 0;

  regfile_uart_dump_if bus ();

  regfile_uart_dump #(.ClksPerBit(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.mem_data = ram[bus.mem_addr];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_clr) begin
      busy_cycles <= 0;
      done_count  <= 0;
    end else begin
      if (bus.busy) busy_cycles <= busy_cycles + 1;
      if (bus.done) done_count  <= done_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_txd"}, 64'(bus.txd), 64'd1);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
  endtask

  // txt holds the five visible characters of each line; CR LF are appended here.
  task automatic run_dump(input logic [7:0] first, input logic [7:0] last, input string txt,
                          input int n, input bit disturb);
    logic [63:0] obs, expv;
    logic [9:0]  fr;
    logic [7:0]  ch;
    bus.first_addr = first;
    bus.last_addr  = last;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int l = 0; l < n; l++) begin
      chk("mem_addr", 64'(bus.mem_addr), 64'(8'(first + 8'(l))));
      chk("busy_fetch", 64'(bus.busy), 64'd1);
      chk("gap_fetch", 64'(bus.txd), 64'd1);
      tick();
      chk("gap_latch", 64'(bus.txd), 64'd1);
      if (disturb && l == 0) begin
        bus.start = 1'b1;
        bus.first_addr = 8'h55;
        bus.last_addr  = 8'h66;
      end
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 7; k++) begin
        ch = (k < 5) ? txt[l * 5 + k] : ((k == 5) ? 8'h0D : 8'h0A);
        fr = {1'b1, ch, 1'b0};
        obs = '0;
        expv = '0;
        for (int i = 0; i < 10 * int'(C); i++) begin
          expv[i] = fr[i / int'(C)];
          obs[i]  = bus.txd;
          if (disturb && l == 0 && k == 1 && i == 5) bus.start = 1'b1;
          tick();
          bus.start = 1'b0;
        end
        chk($sformatf("char_l%0d_c%0d", l, k), obs, expv);
      end
    end
    chk("busy_end", 64'(bus.busy), 64'd0);
    chk("done_pulse", 64'(bus.done), 64'd1);
    tick();
    chk("done_clear", 64'(bus.done), 64'd0);
    chk("busy_cycles", 64'(busy_cycles), 64'(n * (70 * int'(C) + 2)));
    chk("done_count", 64'(done_count), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    bus.start = 1'b0;
    bus.first_addr = 8'h10;
    bus.last_addr = 8'h12;

    // Reset held with start pulses: nothing may move.
    for (int i = 0; i < 4; i++) begin
      bus.start = i[0];
      tick();
      chk_idle("rst_hold");
      chk("rst_addr", 64'(bus.mem_addr), 64'h0);
    end
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (5) tick();
    chk_idle("post_rst");
    chk("post_rst_addr", 64'(bus.mem_addr), 64'h0);

    ram[8'h3C] = 8'hA5;
    run_dump(8'h3C, 8'h3C, "3C:A5", 1, 1'b0);

    ram[8'h09] = 8'h0F;
    ram[8'h0A] = 8'hF0;
    run_dump(8'h09, 8'h0A, "09:0F0A:F0", 2, 1'b0);

    ram[8'hFE] = 8'h12;
    ram[8'hFF] = 8'h34;
    ram[8'h00] = 8'h56;
    ram[8'h01] = 8'h78;
    run_dump(8'hFE, 8'h01, "FE:12FF:3400:5601:78", 4, 1'b0);

    // Start pulses and new range while busy must change nothing.
    run_dump(8'h09, 8'h0A, "09:0F0A:F0", 2, 1'b1);

    // Abort during the third character of a line.
    bus.first_addr = 8'h20;
    bus.last_addr  = 8'h21;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (2 + 2 * 10 * C + 10) tick();
    chk("abort_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    chk_idle("abort");
    chk("abort_addr", 64'(bus.mem_addr), 64'h0);
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1;
      tick();
      chk_idle("abort_hold");
    end
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk_idle("abort_release");

    ram[8'h00] = 8'hC3;
    run_dump(8'h00, 8'h00, "00:C3", 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_uart_dump.md
# regfile_uart_dump

Reads a contiguous address range out of the 256×8 register-file RAM and streams it over a UART TX line as ASCII hex text, one line per address. It is the read-out counterpart of the button-driven regfile editor: the editor writes RAM bytes, this block dumps them to a host terminal. It sits beside the RAM on a second read port and drives the board's serial TX pin.

## Interface
Parameters:
- ClksPerBit, 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset (0: asserted).
- start  input  1  begin a dump; sampled on clk rising edge.
- first_addr  input  8  first address dumped; sampled with start.
- last_addr  input  8  last address dumped; sampled with start.
- mem_addr  output  8  RAM read address.
- mem_data  input  8  RAM read data; must be valid the cycle after mem_addr changes (sync or async read both acceptable).
- txd  output  1  UART serial out, 8N1, LSB first, idle high.
- busy  output  1  high while a dump is in progress.
- done  output  1  one-cycle pulse when the dump completes.

## Operation
- Reset values: txd=1, busy=0, done=0, mem_addr=8'h00; state IDLE.
- States: IDLE -> FETCH -> LATCH -> SEND -> (FETCH | IDLE).
- IDLE: on start=1, latch first/last_addr, mem_addr<=first_addr, busy<=1, go FETCH.
- FETCH: wait one cycle for mem_data. LATCH: capture mem_data into data register, build line, go SEND.
- Line format, 7 characters: addr high nibble, addr low nibble, ':' (0x3A), data high nibble, data low nibble, CR (0x0D), LF (0x0A). Hex digits uppercase: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
- Each character: start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly ClksPerBit cycles. Characters within a line are back-to-back (no idle between stop and next start).
- After LF stop bit: if current addr == last_addr, go IDLE (busy<=0, done pulses 1 cycle); else mem_addr<=mem_addr+1 (8-bit, wraps 8'hFF->8'h00), go FETCH.
- Range: lines dumped = ((last_addr - first_addr) mod 256) + 1. first==last -> 1 line; last<first -> wraps through 0xFF to 0x00.
- start while busy=1: ignored; first/last not re-sampled.
- RAM contents changed mid-dump: each line reports the value captured in its LATCH cycle.
- reset asserted mid-dump: immediately txd=1, busy=0, done=0, current character truncated; no resume after release.

## Timing
- Edge E0 samples start=1 -> busy=1 and mem_addr=first_addr after E0.
- mem_data captured at E2; txd falls (first start bit) after E2.
- One line = 70×ClksPerBit cycles of txd activity.
- Inter-line gap: exactly 2 cycles txd=1 (FETCH, LATCH) between LF stop bit end and next start bit.
- Total dump duration E0 -> busy fall: N×(70×ClksPerBit + 2) cycles, N = line count.
- done high for exactly one cycle, same edge busy falls. A new start is accepted on the cycle after done.

## Test plan
- Reset: hold reset=0 mid-frame with start pulses -> txd=1, busy=0, done=0, mem_addr=0 throughout; release -> stays idle until start.
- Single line, ClksPerBit=4: RAM[0x3C]=0xA5, first=last=0x3C, start pulse -> UART decoder receives "3C:A5\r\n" (0x33,0x43,0x3A,0x41,0x35,0x0D,0x0A), busy high 282 cycles, one done pulse.
- Range with digit boundaries: RAM[0x09]=0x0F, RAM[0x0A]=0xF0, first=0x09, last=0x0A -> "09:0F\r\n0A:F0\r\n", exactly 2 idle cycles between lines.
- Wrap-around: first=0xFE, last=0x01 -> 4 lines for FE, FF, 00, 01 in that order; mem_addr sequence FE,FF,00,01.
- start during busy with different first/last -> ignored; output identical to undisturbed run; done pulses once.
- Reset asserted during third character of a line -> txd=1 next cycle, busy=0; subsequent start with first=last=0x00 produces a clean complete line.
